// File: rtl/nonce_dispatch_scheduler.sv
// Nonce dispatcher and shared-memory arbiter for a bank of SHA-256 phase-2 hash cores.
// Build option: define NDS_RR_ARB_EN for round-robin memory arbitration (default is fixed priority).
//
// state  | meaning
// IDLE   | waiting for start; job parameters captured on start
// RUN    | dispatching nonces to idle cores and counting retires
// FINISH | one-cycle done pulse; busy and grant state cleared
module nonce_dispatch_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int NUM_NONCES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [31:0]             nonce_base,
  input  logic [15:0]             output_addr,
  output logic                    done,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [32*NUM_CORES-1:0] core_nonce,
  output logic [16*NUM_CORES-1:0] core_out_addr,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES-1:0]    core_mem_req,
  input  logic [NUM_CORES-1:0]    core_mem_we,
  input  logic [16*NUM_CORES-1:0] core_mem_addr,
  input  logic [32*NUM_CORES-1:0] core_mem_wdata,
  output logic [NUM_CORES-1:0]    core_mem_gnt,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data
);

  localparam int CW = $clog2(NUM_NONCES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]           state;
  logic [CW-1:0]        issued;
  logic [CW-1:0]        retired;
  logic [CW-1:0]        retired_next;
  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] blank;
  logic [31:0]          base_nonce;
  logic [15:0]          base_addr;

  logic [NUM_CORES-1:0] disp_vec;
  logic                 disp_found;
  logic [31:0]          disp_nonce;
  logic [15:0]          disp_addr;
  logic [NUM_CORES-1:0] retire_vec;

  logic [NUM_CORES-1:0] gnt;
  logic [NUM_CORES-1:0] arb_vec;
  logic                 arb_found;
  logic                 owner_req;

  // Lowest-index idle core takes the next nonce.
  always_comb begin
    disp_vec   = '0;
    disp_found = 1'b0;
    if (state == S_RUN && issued < CW'(NUM_NONCES)) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (!disp_found && !busy[k] && core_done[k]) begin
          disp_found  = 1'b1;
          disp_vec[k] = 1'b1;
        end
      end
    end
  end

  assign disp_nonce = base_nonce + 32'(issued);
  assign disp_addr  = base_addr + (16'(issued) << 3);

  // A core's done level is stale during its start pulse and the cycle after.
  always_comb begin
    retire_vec = '0;
    if (state == S_RUN) retire_vec = busy & core_done & ~core_start & ~blank;
    retired_next = retired;
    for (int k = 0; k < NUM_CORES; k++) begin
      retired_next = retired_next + CW'(retire_vec[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      issued        <= '0;
      retired       <= '0;
      busy          <= '0;
      blank         <= '0;
      base_nonce    <= '0;
      base_addr     <= '0;
      done          <= 1'b0;
      core_start    <= '0;
      core_nonce    <= '0;
      core_out_addr <= '0;
    end else begin
      core_start <= '0;
      done       <= 1'b0;
      blank      <= core_start;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_RUN;
            issued     <= '0;
            retired    <= '0;
            base_nonce <= nonce_base;
            base_addr  <= output_addr;
          end
        end
        S_RUN: begin
          retired <= retired_next;
          busy    <= (busy & ~retire_vec) | disp_vec;
          if (disp_found) begin
            issued     <= issued + CW'(1);
            core_start <= disp_vec;
            for (int k = 0; k < NUM_CORES; k++) begin
              if (disp_vec[k]) begin
                core_nonce[32*k +: 32]    <= disp_nonce;
                core_out_addr[16*k +: 16] <= disp_addr;
              end
            end
          end
          if (retired_next == CW'(NUM_NONCES)) begin
            state <= S_FINISH;
            done  <= 1'b1;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          busy  <= '0;
          blank <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef NDS_RR_ARB_EN
  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [IW-1:0] last_owner;
  logic [IW-1:0] arb_idx;
  int            cand;

  always_comb begin
    arb_vec   = '0;
    arb_found = 1'b0;
    arb_idx   = last_owner;
    cand      = 0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      cand = (int'(last_owner) + i) % NUM_CORES;
      if (!arb_found && core_mem_req[cand]) begin
        arb_found     = 1'b1;
        arb_vec[cand] = 1'b1;
        arb_idx       = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) last_owner <= IW'(NUM_CORES - 1);
    else if (state != S_FINISH && gnt == '0 && arb_found) last_owner <= arb_idx;
  end
`else
  always_comb begin
    arb_vec   = '0;
    arb_found = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!arb_found && core_mem_req[k]) begin
        arb_found  = 1'b1;
        arb_vec[k] = 1'b1;
      end
    end
  end
`endif

  assign owner_req = |(gnt & core_mem_req);

  // Locked burst: grant holds while the owner requests; one idle cycle after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt <= '0;
    end else if (state == S_FINISH) begin
      gnt <= '0;
    end else if (gnt != '0) begin
      if (!owner_req) gnt <= '0;
    end else begin
      gnt <= arb_vec;
    end
  end

  assign core_mem_gnt = gnt;

  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (gnt[k]) begin
        mem_we         = core_mem_we[k];
        mem_addr       = core_mem_addr[16*k +: 16];
        mem_write_data = core_mem_wdata[32*k +: 32];
      end
    end
  end

endmodule

// File: tb/tb_nonce_dispatch_scheduler.sv
// Directed bench for nonce_dispatch_scheduler (4 cores, 6 nonces per job).
module tb_nonce_dispatch_scheduler;
  localparam int NC = 4;
  localparam int NN = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   nonce_base;
  logic [15:0]   output_addr;
  logic          done;
  logic [NC-1:0] core_start;
  logic [32*NC-1:0] core_nonce;
  logic [16*NC-1:0] core_out_addr;
  logic [NC-1:0] core_done;
  logic [NC-1:0] core_mem_req;
  logic [NC-1:0] core_mem_we;
  logic [16*NC-1:0] core_mem_addr;
  logic [32*NC-1:0] core_mem_wdata;
  logic [NC-1:0] core_mem_gnt;
  logic          mem_we;
  logic [15:0]   mem_addr;
  logic [31:0]   mem_write_data;

  int checks = 0;
  int errors = 0;

  nonce_dispatch_scheduler #(.NUM_CORES(NC), .NUM_NONCES(NN)) dut (
    .clk(clk), .reset(reset), .start(start), .nonce_base(nonce_base),
    .output_addr(output_addr), .done(done), .core_start(core_start),
    .core_nonce(core_nonce), .core_out_addr(core_out_addr), .core_done(core_done),
    .core_mem_req(core_mem_req), .core_mem_we(core_mem_we), .core_mem_addr(core_mem_addr),
    .core_mem_wdata(core_mem_wdata), .core_mem_gnt(core_mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the index of the first core_start pulse, or -1 after a bounded wait.
  task automatic wait_start(output int idx);
    int n;
    idx = -1;
    n = 0;
    while (idx < 0 && n < 30) begin
      if (core_start != '0) begin
        for (int k = 0; k < NC; k++) if (core_start[k]) idx = k;
      end else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (core_start !== 4'b0000) begin errors++; $display("FAIL reset_core_start got %b exp 0000", core_start); end
    checks++; if (core_nonce !== '0) begin errors++; $display("FAIL reset_core_nonce got %h exp 0", core_nonce); end
    checks++; if (core_out_addr !== '0) begin errors++; $display("FAIL reset_core_out_addr got %h exp 0", core_out_addr); end
    checks++; if (core_mem_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", core_mem_gnt); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b exp 0", mem_we); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_dispatch();
    logic [31:0] exp_n [4] = '{32'h100, 32'h101, 32'h102, 32'h103};
    logic [15:0] exp_a [4] = '{16'h40, 16'h48, 16'h50, 16'h58};
    logic [NC-1:0] exp_s;
    int idx;
    core_done   = '1;
    nonce_base  = 32'h100;
    output_addr = 16'h40;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_start(idx);
    checks++; if (idx !== 0) begin errors++; $display("FAIL disp_first_core got %0d exp 0", idx); end
    for (int i = 0; i < 4; i++) begin
      exp_s = '0;
      exp_s[i] = 1'b1;
      checks++; if (core_start !== exp_s) begin errors++; $display("FAIL disp_start_%0d got %b exp %b", i, core_start, exp_s); end
      checks++; if (core_nonce[32*i +: 32] !== exp_n[i]) begin errors++; $display("FAIL disp_nonce_%0d got %h exp %h", i, core_nonce[32*i +: 32], exp_n[i]); end
      checks++; if (core_out_addr[16*i +: 16] !== exp_a[i]) begin errors++; $display("FAIL disp_addr_%0d got %h exp %h", i, core_out_addr[16*i +: 16], exp_a[i]); end
      core_done[i] = 1'b0;
      tick();
    end
    checks++; if (core_start !== 4'b0000) begin errors++; $display("FAIL disp_all_busy got %b exp 0000", core_start); end
    tick();
    checks++; if (core_nonce[31:0] !== 32'h100) begin errors++; $display("FAIL disp_hold got %h exp 00000100", core_nonce[31:0]); end
  endtask

  task automatic test_retire_done();
    int idx;
    int pulses;
    nonce_base = 32'hDEAD_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    nonce_base = 32'h100;
    repeat (48) tick();
    core_done[2] = 1'b1;
    wait_start(idx);
    checks++; if (idx !== 2) begin errors++; $display("FAIL retire_first_core got %0d exp 2", idx); end
    checks++; if (core_nonce[95:64] !== 32'h104) begin errors++; $display("FAIL retire_nonce4 got %h exp 00000104", core_nonce[95:64]); end
    checks++; if (core_out_addr[47:32] !== 16'h60) begin errors++; $display("FAIL retire_addr4 got %h exp 0060", core_out_addr[47:32]); end
    tick();
    core_done[2] = 1'b0;
    tick();
    core_done[0] = 1'b1;
    wait_start(idx);
    checks++; if (idx !== 0) begin errors++; $display("FAIL retire_second_core got %0d exp 0", idx); end
    checks++; if (core_nonce[31:0] !== 32'h105) begin errors++; $display("FAIL retire_nonce5 got %h exp 00000105", core_nonce[31:0]); end
    checks++; if (core_out_addr[15:0] !== 16'h68) begin errors++; $display("FAIL retire_addr5 got %h exp 0068", core_out_addr[15:0]); end
    core_done[0] = 1'b0;
    repeat (5) tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_early got %0b exp 0", done); end
    core_done = '1;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse got %0b exp 1", done); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL done_extra got %0d exp 0", pulses); end
    checks++; if (core_start !== 4'b0000) begin errors++; $display("FAIL idle_no_start got %b exp 0000", core_start); end
  endtask

  task automatic test_arbiter();
    core_mem_addr  = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    core_mem_wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0};
    core_mem_we    = 4'b1010;
    core_mem_req   = 4'b1010;
    #1;
    checks++; if (core_mem_gnt !== 4'b0000) begin errors++; $display("FAIL arb_registered got %b exp 0000", core_mem_gnt); end
    tick();
    checks++; if (core_mem_gnt !== 4'b0010) begin errors++; $display("FAIL arb_gnt1 got %b exp 0010", core_mem_gnt); end
    checks++; if (mem_addr !== 16'h1111) begin errors++; $display("FAIL arb_addr1 got %h exp 1111", mem_addr); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL arb_we1 got %0b exp 1", mem_we); end
    checks++; if (mem_write_data !== 32'h1111_1111) begin errors++; $display("FAIL arb_wdata1 got %h exp 11111111", mem_write_data); end
    core_mem_req[1] = 1'b0;
    tick();
    checks++; if (core_mem_gnt !== 4'b0000) begin errors++; $display("FAIL arb_gap got %b exp 0000", core_mem_gnt); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL arb_gap_addr got %h exp 0000", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL arb_gap_we got %0b exp 0", mem_we); end
    tick();
    checks++; if (core_mem_gnt !== 4'b1000) begin errors++; $display("FAIL arb_gnt3 got %b exp 1000", core_mem_gnt); end
    checks++; if (mem_addr !== 16'h3333) begin errors++; $display("FAIL arb_addr3 got %h exp 3333", mem_addr); end
    core_mem_addr[63:48] = 16'h3456;
    #1;
    checks++; if (mem_addr !== 16'h3456) begin errors++; $display("FAIL arb_track3 got %h exp 3456", mem_addr); end
    core_mem_req = '0;
    core_mem_we  = '0;
    tick();
    checks++; if (core_mem_gnt !== 4'b0000) begin errors++; $display("FAIL arb_release got %b exp 0000", core_mem_gnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    int exp_o [4];
    int got_o [4];
    int cnt [NC];
    int n_got;
    logic [NC-1:0] g;
    logic [NC-1:0] prev;
`ifdef NDS_RR_ARB_EN
    exp_o = '{0, 2, 0, 2};
`else
    exp_o = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < NC; k++) cnt[k] = 0;
    for (int i = 0; i < 4; i++) got_o[i] = -1;
    n_got = 0;
    prev = core_mem_gnt;
    for (int c = 0; c < 40 && n_got < 4; c++) begin
      g = core_mem_gnt;
      if (g != '0 && prev == '0) begin
        for (int k = 0; k < NC; k++) if (g[k]) got_o[n_got] = k;
        n_got++;
      end
      for (int k = 0; k < NC; k += 2) begin
        if (core_mem_req[k] && g[k]) begin
          cnt[k]++;
          if (cnt[k] == 2) begin
            core_mem_req[k] = 1'b0;
            cnt[k] = 0;
          end
        end else if (!core_mem_req[k]) begin
          core_mem_req[k] = 1'b1;
        end
      end
      prev = g;
      tick();
    end
    checks++; if (n_got !== 4) begin errors++; $display("FAIL burst_count got %0d exp 4", n_got); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_o[i] !== exp_o[i]) begin errors++; $display("FAIL burst_owner_%0d got %0d exp %0d", i, got_o[i], exp_o[i]); end
    end
    core_mem_req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_job();
    int idx;
    core_done   = 4'b0011;
    nonce_base  = 32'h500;
    output_addr = 16'h200;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_start(idx);
    checks++; if (idx !== 0) begin errors++; $display("FAIL abort_pre_core got %0d exp 0", idx); end
    core_done[0] = 1'b0;
    tick();
    checks++; if (core_start !== 4'b0010) begin errors++; $display("FAIL abort_pre_start1 got %b exp 0010", core_start); end
    core_done[1] = 1'b0;
    core_mem_req = 4'b0010;
    core_mem_we  = 4'b0010;
    tick();
    checks++; if (core_mem_gnt !== 4'b0010) begin errors++; $display("FAIL abort_pre_gnt got %b exp 0010", core_mem_gnt); end
    reset = 1'b1;
    tick();
    checks++; if (core_mem_gnt !== 4'b0000) begin errors++; $display("FAIL abort_gnt got %b exp 0000", core_mem_gnt); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL abort_mem_we got %0b exp 0", mem_we); end
    checks++; if (core_start !== 4'b0000) begin errors++; $display("FAIL abort_start got %b exp 0000", core_start); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %0b exp 0", done); end
    checks++; if (dut.state !== 2'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", dut.state); end
    reset = 1'b0;
    core_mem_req = '0;
    core_mem_we  = '0;
    core_done = 4'b0011;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_start(idx);
    checks++; if (idx !== 0) begin errors++; $display("FAIL restart_core got %0d exp 0", idx); end
    checks++; if (core_nonce[31:0] !== 32'h500) begin errors++; $display("FAIL restart_nonce got %h exp 00000500", core_nonce[31:0]); end
    checks++; if (core_out_addr[15:0] !== 16'h200) begin errors++; $display("FAIL restart_addr got %h exp 0200", core_out_addr[15:0]); end
    core_done[0] = 1'b0;
    tick();
    checks++; if (core_nonce[63:32] !== 32'h501) begin errors++; $display("FAIL restart_nonce1 got %h exp 00000501", core_nonce[63:32]); end
    checks++; if (core_out_addr[31:16] !== 16'h208) begin errors++; $display("FAIL restart_addr1 got %h exp 0208", core_out_addr[31:16]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] exp_n [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    logic [15:0] exp_a [4] = '{16'hFFF8, 16'h0000, 16'h0008, 16'h0010};
    int idx;
    core_done   = '1;
    nonce_base  = 32'hFFFF_FFFE;
    output_addr = 16'hFFF8;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_start(idx);
    checks++; if (idx !== 0) begin errors++; $display("FAIL wrap_first_core got %0d exp 0", idx); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (core_nonce[32*i +: 32] !== exp_n[i]) begin errors++; $display("FAIL wrap_nonce_%0d got %h exp %h", i, core_nonce[32*i +: 32], exp_n[i]); end
      checks++; if (core_out_addr[16*i +: 16] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr_%0d got %h exp %h", i, core_out_addr[16*i +: 16], exp_a[i]); end
      core_done[i] = 1'b0;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    nonce_base     = '0;
    output_addr    = '0;
    core_done      = '1;
    core_mem_req   = '0;
    core_mem_we    = '0;
    core_mem_addr  = '0;
    core_mem_wdata = '0;
    test_reset();
    test_dispatch();
    test_retire_done();
    test_arbiter();
    test_back_to_back();
    test_reset_mid_job();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
